// File: rtl/mpu_isa_pkg.sv
// rtl/mpu_isa_pkg.sv - ISA constants for the 8-bit MPU: opcode classes, dest/source codes, reg_en bit indices
package mpu_isa_pkg;

    typedef enum logic [2:0] {
        CLS_LOAD = 3'd0,
        CLS_MOV  = 3'd1,
        CLS_ALU  = 3'd2,
        CLS_JMP  = 3'd3,
        CLS_JNZ  = 3'd4
    } op_class_t;

    localparam logic [2:0] DEST_X0    = 3'd0;
    localparam logic [2:0] DEST_X1    = 3'd1;
    localparam logic [2:0] DEST_Y0    = 3'd2;
    localparam logic [2:0] DEST_Y1    = 3'd3;
    localparam logic [2:0] DEST_O_REG = 3'd4;
    localparam logic [2:0] DEST_M     = 3'd5;
    localparam logic [2:0] DEST_I     = 3'd6;
    localparam logic [2:0] DEST_DM    = 3'd7;

    localparam logic [2:0] SRC_DM        = 3'd7;
    localparam logic [3:0] SRC_ALU_X0    = 4'd0;
    localparam logic [3:0] SRC_IR_NIBBLE = 4'd8;
    localparam logic [3:0] SRC_I_PINS    = 4'd9;

    localparam int REG_R     = 4;
    localparam int REG_I     = 6;
    localparam int REG_O_REG = 8;

    function automatic op_class_t classify(input logic [7:0] ir);
        if (!ir[7])             return CLS_LOAD;
        else if (!ir[6])        return CLS_MOV;
        else if (!ir[5])        return CLS_ALU;
        else if (!ir[4])        return CLS_JMP;
        else                    return CLS_JNZ;
    endfunction

endpackage

// File: rtl/dest_decoder.sv
// rtl/dest_decoder.sv - 3-bit destination code to 9-bit one-hot register enable
module dest_decoder
    import mpu_isa_pkg::*;
(
    input  logic [2:0] dest_code,
    output logic [8:0] reg_en
);

    // Code 4 addresses the output register, whose enable sits above the r slot
    always_comb begin
        reg_en = 9'h000;
        if (dest_code == DEST_O_REG) reg_en[REG_O_REG] = 1'b1;
        else                         reg_en[dest_code] = 1'b1;
    end

endmodule

// File: rtl/instr_decoder.sv
// rtl/instr_decoder.sv - MPU instruction register and decoder; DM_AUTO_INC_EN enables i auto-increment on dm access
module instr_decoder
    import mpu_isa_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] next_instr,
    output logic       jmp,
    output logic       jmp_nz,
    output logic [3:0] ir_nibble,
    output logic       i_sel,
    output logic       y_sel,
    output logic       x_sel,
    output logic [3:0] source_sel,
    output logic [8:0] reg_en
);

    logic [7:0] ir_q, ir_d;
    logic       valid_q, valid_d;

    always_comb begin
        ir_d    = next_instr;
        valid_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ir_q    <= 8'h00;
            valid_q <= 1'b0;
        end else begin
            ir_q    <= ir_d;
            valid_q <= valid_d;
        end
    end

    op_class_t  op_class;
    logic [2:0] dest_code;
    logic [2:0] src_code;
    logic [8:0] dest_en;

    assign op_class  = classify(ir_q);
    assign dest_code = (op_class == CLS_LOAD) ? ir_q[6:4] : ir_q[5:3];
    assign src_code  = ir_q[2:0];

    dest_decoder u_dest_decoder (
        .dest_code (dest_code),
        .reg_en    (dest_en)
    );

    assign ir_nibble = ir_q[3:0];
    assign x_sel     = ir_q[4];
    assign y_sel     = ir_q[3];

    always_comb begin
        reg_en     = 9'h000;
        source_sel = SRC_ALU_X0;
        i_sel      = 1'b0;
        jmp        = 1'b0;
        jmp_nz     = 1'b0;
        if (valid_q) begin
            case (op_class)
                CLS_LOAD: begin
                    reg_en     = dest_en;
                    source_sel = SRC_IR_NIBBLE;
                end
                CLS_MOV: begin
                    reg_en     = dest_en;
                    source_sel = (dest_code == src_code) ? SRC_I_PINS : {1'b0, src_code};
                end
                CLS_ALU: reg_en[REG_R] = 1'b1;
                CLS_JMP: jmp           = 1'b1;
                CLS_JNZ: jmp_nz        = 1'b1;
                default: ;
            endcase
`ifdef DM_AUTO_INC_EN
            if ((op_class == CLS_LOAD || op_class == CLS_MOV) &&
                (dest_code == DEST_DM || (op_class == CLS_MOV && src_code == SRC_DM))) begin
                reg_en[REG_I] = 1'b1;
                i_sel         = 1'b1;
            end
`endif
            // Explicit write of i takes the source bus, never the increment path
            if ((op_class == CLS_LOAD || op_class == CLS_MOV) && dest_code == DEST_I)
                i_sel = 1'b0;
        end
    end

endmodule

// File: tb/tb_instr_decoder.sv
// tb/tb_instr_decoder.sv - self-checking bench for instr_decoder (directed table, sweep, reset sequences)
module tb_instr_decoder;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] next_instr;
    logic       jmp, jmp_nz, i_sel, y_sel, x_sel;
    logic [3:0] ir_nibble, source_sel;
    logic [8:0] reg_en;

    instr_decoder dut (
        .clk        (clk),
        .reset      (reset),
        .next_instr (next_instr),
        .jmp        (jmp),
        .jmp_nz     (jmp_nz),
        .ir_nibble  (ir_nibble),
        .i_sel      (i_sel),
        .y_sel      (y_sel),
        .x_sel      (x_sel),
        .source_sel (source_sel),
        .reg_en     (reg_en)
    );

    always #5 clk = ~clk;

`ifdef DM_AUTO_INC_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    typedef struct packed {
        logic [8:0] reg_en;
        logic [3:0] src;
        logic       i_sel;
        logic       x_sel;
        logic       y_sel;
        logic       jmp;
        logic       jmp_nz;
        logic [3:0] nib;
    } exp_t;

    typedef struct {
        logic [7:0] instr;
        exp_t       exp;
    } vec_t;

    exp_t q[$];
    int   pass_cnt  = 0;
    int   check_cnt = 0;

    function automatic exp_t mk(input logic [8:0] re, input logic [3:0] src, input logic is,
                                input logic xs, input logic ys, input logic j, input logic jn,
                                input logic [3:0] nib);
        exp_t e;
        e.reg_en = re; e.src = src; e.i_sel = is; e.x_sel = xs; e.y_sel = ys;
        e.jmp = j; e.jmp_nz = jn; e.nib = nib;
        return e;
    endfunction

    function automatic logic [8:0] dmask(input logic [2:0] d);
        case (d)
            3'd0: return 9'h001;
            3'd1: return 9'h002;
            3'd2: return 9'h004;
            3'd3: return 9'h008;
            3'd4: return 9'h100;
            3'd5: return 9'h020;
            3'd6: return 9'h040;
            default: return 9'h080;
        endcase
    endfunction

    function automatic exp_t model(input logic [7:0] b);
        exp_t e;
        logic [2:0] d, s;
        e = '0;
        e.x_sel = b[4]; e.y_sel = b[3]; e.nib = b[3:0];
        d = b[5:3]; s = b[2:0];
        casez (b)
            8'b0???_????: begin
                d = b[6:4];
                e.reg_en = dmask(d);
                e.src = 4'd8;
                if (AUTO && d == 3'd7) begin e.reg_en |= 9'h040; e.i_sel = 1'b1; end
            end
            8'b10??_????: begin
                e.reg_en = dmask(d);
                e.src = (d == s) ? 4'd9 : {1'b0, s};
                if (AUTO && d != 3'd6 && (d == 3'd7 || s == 3'd7)) begin
                    e.reg_en |= 9'h040; e.i_sel = 1'b1;
                end
            end
            8'b110?_????: e.reg_en = 9'h010;
            8'b1110_????: e.jmp = 1'b1;
            default:      e.jmp_nz = 1'b1;
        endcase
        return e;
    endfunction

    function automatic exp_t actual();
        return mk(reg_en, source_sel, i_sel, x_sel, y_sel, jmp, jmp_nz, ir_nibble);
    endfunction

    task automatic check(input string name);
        exp_t e, a;
        check_cnt++;
        if (q.size() == 0) begin
            $display("FAIL %s: scoreboard empty", name);
            return;
        end
        e = q.pop_front();
        a = actual();
        if (a === e) pass_cnt++;
        else $display("FAIL %s: actual %h required %h", name, a, e);
    endtask

    task automatic apply(input logic [7:0] b, input exp_t e, input string name);
        @(negedge clk);
        next_instr = b;
        q.push_back(e);
        @(posedge clk);
        #1;
        check(name);
    endtask

    vec_t vt[12];

    initial begin
        vt[0]  = '{8'h00, mk(9'h001, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0)};
        vt[1]  = '{8'h75, mk(AUTO ? 9'h0C0 : 9'h080, 4'd8, AUTO, 1'b1, 1'b0, 1'b0, 1'b0, 4'h5)};
        vt[2]  = '{8'h8C, mk(9'h002, 4'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'hC)};
        vt[3]  = '{8'h8D, mk(9'h002, 4'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'hD)};
        vt[4]  = '{8'hA4, mk(9'h100, 4'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h4)};
        vt[5]  = '{8'hA3, mk(9'h100, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h3)};
        vt[6]  = '{8'h89, mk(9'h002, 4'd9, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h9)};
        vt[7]  = '{8'hB7, mk(9'h040, 4'd7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h7)};
        vt[8]  = '{8'hBE, mk(AUTO ? 9'h0C0 : 9'h080, 4'd6, AUTO, 1'b1, 1'b1, 1'b0, 1'b0, 4'hE)};
        vt[9]  = '{8'hD8, mk(9'h010, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h8)};
        vt[10] = '{8'hE3, mk(9'h000, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h3)};
        vt[11] = '{8'hF3, mk(9'h000, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'h3)};

        reset = 1'b1;
        next_instr = 8'h75;
        repeat (3) @(posedge clk);
        #1;
        q.push_back('0);
        check("reset_hold");

        @(negedge clk);
        reset = 1'b0;
        next_instr = 8'h00;
        q.push_back(mk(9'h001, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0));
        @(posedge clk);
        #1;
        check("reset_release_first");

        for (int i = 0; i < 12; i++)
            apply(vt[i].instr, vt[i].exp, $sformatf("dir[%0d]_%h", i, vt[i].instr));

        for (int v = 0; v < 256; v++)
            apply(8'(v), model(8'(v)), $sformatf("sweep_%h", 8'(v)));

        // Asynchronous reset between edges must clear strobes immediately
        apply(8'hE3, model(8'hE3), "pre_async_jmp");
        #2;
        reset = 1'b1;
        #1;
        q.push_back('0);
        check("async_reset_now");
        @(posedge clk);
        #1;
        q.push_back('0);
        check("async_reset_edge");
        @(negedge clk);
        reset = 1'b0;
        apply(8'hF3, model(8'hF3), "post_async_jnz");

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
